// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad emulator and the scanner/decoder side:
// FSM states, bounce LFSR constants and the single key map.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_IN,
    HOLD,
    BOUNCE_OUT,
    GAP
  } kpe_state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Returns {row[1:0], col[1:0]} for a hex key value.
  function automatic logic [3:0] key_to_rowcol(input logic [3:0] key);
    logic [3:0] rc;
    case (key)
      4'h1: rc = {2'd0, 2'd0};
      4'h2: rc = {2'd0, 2'd1};
      4'h3: rc = {2'd0, 2'd2};
      4'hA: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd0};
      4'h5: rc = {2'd1, 2'd1};
      4'h6: rc = {2'd1, 2'd2};
      4'hB: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd0};
      4'h8: rc = {2'd2, 2'd1};
      4'h9: rc = {2'd2, 2'd2};
      4'hC: rc = {2'd2, 2'd3};
      4'hE: rc = {2'd3, 2'd0};
      4'h0: rc = {2'd3, 2'd1};
      4'hF: rc = {2'd3, 2'd2};
      4'hD: rc = {2'd3, 2'd3};
      default: rc = 4'b0000;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the contact chatter source.
module bounce_lfsr
  import keypad_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] out
);

  // The seed is non-zero and the polynomial is maximal, so all-zero never occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= LFSR_SEED;
    else       out <= {out[14:0], ^(out & LFSR_TAPS)};
  end

endmodule

// File: rtl/keypad_emulator.sv
// Responder side of a 4x4 row-scan keypad: emulates one pressed key at a time,
// with contact chatter on press and release, driven by a request handshake.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_W        = 24,
  parameter int BOUNCE_CYCLES = 4096,
  parameter int GAP_W         = 22,
  parameter int GAP_CYCLES    = 2500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        rows,
  output logic [3:0]        cols,
  input  logic              req_valid,
  input  logic [3:0]        req_key,
  input  logic [HOLD_W-1:0] req_hold,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              contact
);

  localparam int BOUNCE_W = $clog2(BOUNCE_CYCLES);
  localparam int CNT_A    = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;
  localparam int CNT_W    = (CNT_A > BOUNCE_W) ? CNT_A : BOUNCE_W;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  kpe_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [3:0]        rows_meta, rows_s;
  logic [1:0]        key_row, key_col;
  logic [HOLD_W-1:0] hold_len;
  logic [15:0]       lfsr;
  logic              unused_lfsr;
  logic              accept, done_next;

  bounce_lfsr u_lfsr (
    .clk   (clk),
    .reset (reset),
    .out   (lfsr)
  );

  assign unused_lfsr = ^lfsr[15:1];
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = req_valid && req_ready;

  // rows comes from another clock domain; two flops before any use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta <= 4'b0000;
      rows_s    <= 4'b0000;
    end else begin
      rows_meta <= rows;
      rows_s    <= rows_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Request fields are captured once; a zero hold still gives one HOLD cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_row  <= 2'd0;
      key_col  <= 2'd0;
      hold_len <= HOLD_W'(1);
    end else if (accept) begin
      {key_row, key_col} <= key_to_rowcol(req_key);
      hold_len <= (req_hold == '0) ? HOLD_W'(1) : req_hold;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cols <= 4'b0000;
      done <= 1'b0;
    end else begin
      cols <= (contact && rows_s[key_row]) ? (4'b0001 << key_col) : 4'b0000;
      done <= done_next;
    end
  end

  // Every state change reloads the down-counter, so it never wraps.
  always_comb begin
    state_next = state;
    cnt_next   = (cnt == '0) ? cnt : cnt - ONE;
    contact    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = BOUNCE_IN;
          cnt_next   = CNT_W'(BOUNCE_CYCLES - 1);
        end
      end
      BOUNCE_IN: begin
        contact = lfsr[0];
        if (cnt == '0) begin
          state_next = HOLD;
          cnt_next   = CNT_W'(hold_len) - ONE;
        end
      end
      HOLD: begin
        contact = 1'b1;
        if (cnt == '0) begin
          state_next = BOUNCE_OUT;
          cnt_next   = CNT_W'(BOUNCE_CYCLES - 1);
        end
      end
      BOUNCE_OUT: begin
        contact = lfsr[0];
        if (cnt == '0) begin
          state_next = GAP;
          cnt_next   = CNT_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
